// File: rtl/wb_pwm.sv
// wb_pwm: Wishbone timer/PWM peripheral.
// It has a prescaled up-counter with a programmable period and CHANNELS
// double-buffered compare outputs. A wrap flag raises a level interrupt.
// The bus uses a zero-wait handshake: ack equals strobe and reads are combinational.
module wb_pwm #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CWIDTH   = 16
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [3:0]          adr_i,
    input  logic [31:0]         dat_i,
    output logic [31:0]         dat_o,
    input  logic                we_i,
    input  logic                stb_i,
    output logic                ack_o,
    output logic [CHANNELS-1:0] pwm,
    output logic                irq
);

    // Control register fields
    logic              ctrl_en;
    logic              ctrl_ie;
    logic [7:0]        ctrl_pre;

    // Shadow registers are written by the bus. Active registers drive the outputs.
    logic [CWIDTH-1:0] period_s;
    logic [CWIDTH-1:0] period_a;
    logic [CWIDTH-1:0] duty_s [CHANNELS];
    logic [CWIDTH-1:0] duty_a [CHANNELS];

    // Timebase
    logic [7:0]        presc;
    logic [CWIDTH-1:0] count;
    logic              tick;
    logic              wrap_evt;
    logic              wrap_flag;

    // Bus write decode
    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_period;
    logic              wr_status;
    logic              wr_count;
    logic [CHANNELS-1:0] wr_duty;
    logic [CWIDTH-1:0] wdata;

    // The upper data bits are only partly used, depending on CWIDTH.
    logic              unused_dat;

    assign unused_dat = ^dat_i;
    assign wdata      = dat_i[CWIDTH-1:0];
    assign wr_en      = stb_i & we_i;
    assign ack_o      = stb_i;
    assign irq        = wrap_flag & ctrl_ie;

    // Decode the word index into per-register write strobes.
    always_comb begin
        wr_ctrl   = wr_en && (adr_i == 4'd0);
        wr_period = wr_en && (adr_i == 4'd1);
        wr_status = wr_en && (adr_i == 4'd2);
        wr_count  = wr_en && (adr_i == 4'd3);
        wr_duty   = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            wr_duty[n] = wr_en && (adr_i == 4'(4 + n));
        end
    end

    // A tick occurs when the prescaler reaches PRE. A wrap occurs when a tick finds the counter at the period.
    // A COUNT write suppresses both the increment and the wrap in that cycle.
    always_comb begin
        tick     = ctrl_en && (presc == ctrl_pre);
        wrap_evt = tick && !wr_count && (count == period_a);
    end

    // Control register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
            ctrl_pre <= '0;
        end else if (wr_ctrl) begin
            ctrl_en  <= dat_i[0];
            ctrl_ie  <= dat_i[1];
            ctrl_pre <= dat_i[15:8];
        end
    end

    // Period and duty shadow registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            period_s <= '0;
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                duty_s[n] <= '0;
            end
        end else begin
            if (wr_period) begin
                period_s <= wdata;
            end
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (wr_duty[n]) begin
                    duty_s[n] <= wdata;
                end
            end
        end
    end

    // Actives follow the shadows every cycle while disabled, and once per wrap while running.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            period_a <= '0;
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                duty_a[n] <= '0;
            end
        end else if (!ctrl_en || wrap_evt) begin
            period_a <= period_s;
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                duty_a[n] <= duty_s[n];
            end
        end
    end

    // Prescaler: it runs while enabled, returns to 0 on tick, and is cleared by a COUNT write.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            presc <= '0;
        end else if (wr_count) begin
            presc <= '0;
        end else if (ctrl_en) begin
            presc <= tick ? 8'd0 : presc + 8'd1;
        end
    end

    // Counter: a bus load has priority over the tick.
    // A loaded value above the period counts up, rolls over at 2^CWIDTH and does not wrap.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wdata;
        end else if (tick) begin
            count <= (count == period_a) ? '0 : count + CWIDTH'(1);
        end
    end

    // Wrap flag: it is set by a wrap and cleared by writing 1. The set wins if both happen in one cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wrap_flag <= 1'b0;
        end else if (wrap_evt) begin
            wrap_flag <= 1'b1;
        end else if (wr_status && dat_i[0]) begin
            wrap_flag <= 1'b0;
        end
    end

    // PWM outputs are registered compares against the active duty values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pwm <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                pwm[n] <= ctrl_en && (count < duty_a[n]);
            end
        end
    end

    // Read-back mux. It is zero-extended, and unmapped indices read 0.
    always_comb begin
        dat_o = '0;
        case (adr_i)
            4'd0: dat_o = {16'h0000, ctrl_pre, 6'b000000, ctrl_ie, ctrl_en};
            4'd1: dat_o[CWIDTH-1:0] = period_s;
            4'd2: dat_o[0] = wrap_flag;
            4'd3: dat_o[CWIDTH-1:0] = count;
            default: begin
                for (int unsigned n = 0; n < CHANNELS; n++) begin
                    if (adr_i == 4'(4 + n)) begin
                        dat_o[CWIDTH-1:0] = duty_s[n];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_wb_pwm.sv
// Self-checking bench for wb_pwm.
// A register vector table runs first, then hand-computed sequences cover the timing cases.
module tb_wb_pwm;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 16;

    logic          clk   = 1'b0;
    logic          arst  = 1'b1;
    logic [3:0]    adr_i = '0;
    logic [31:0]   dat_i = '0;
    logic          we_i  = 1'b0;
    logic          stb_i = 1'b0;
    logic [31:0]   dat_o;
    logic          ack_o;
    logic [CH-1:0] pwm;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_pwm #(.CHANNELS(CH), .CWIDTH(CW)) dut (
        .clk   (clk),
        .arst  (arst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .ack_o (ack_o),
        .pwm   (pwm),
        .irq   (irq)
    );

    typedef struct {
        logic        do_wr;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        adr_i = a; dat_i = d; we_i = 1'b1; stb_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        adr_i = a;
        #1;
        d = dat_o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] v;
        logic [31:0] st;
        logic [CH-1:0] ep;

        // Register read/write vectors. EN stays 0 throughout, so nothing counts.
        vecs[0]  = '{1'b0, 4'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b1, 4'd0,  32'hFFFF_FF02, 32'h0000_FF02};
        vecs[2]  = '{1'b1, 4'd1,  32'hABCD_1234, 32'h0000_1234};
        vecs[3]  = '{1'b1, 4'd4,  32'h0001_0005, 32'h0000_0005};
        vecs[4]  = '{1'b1, 4'd7,  32'h0000_FFFF, 32'h0000_FFFF};
        vecs[5]  = '{1'b1, 4'd8,  32'h0000_FFFF, 32'h0000_0000};
        vecs[6]  = '{1'b1, 4'd15, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{1'b1, 4'd3,  32'h0000_0042, 32'h0000_0042};
        vecs[8]  = '{1'b0, 4'd3,  32'h0000_0000, 32'h0000_0042};
        vecs[9]  = '{1'b1, 4'd2,  32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{1'b0, 4'd0,  32'h0000_0000, 32'h0000_FF02};
        vecs[11] = '{1'b1, 4'd0,  32'h0000_0000, 32'h0000_0000};

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("reset_pwm", 32'(pwm), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_ack", 32'(ack_o), 32'h0);
        arst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].adr, vecs[i].wdat);
            rd(vecs[i].adr, v);
            chk($sformatf("regvec[%0d]", i), v, vecs[i].exp);
        end
        chk("regvec_irq", 32'(irq), 32'h0);

        // Basic PWM: PERIOD=9, DUTY0=3, EN+IE.
        // Sample i follows edge 1+i, where count=(i+1)%10 and pwm0=(i%10)<3.
        // A W1C lands exactly on the wrap at i=19. A plain W1C lands at i=23.
        do_reset();
        wr(4'd1, 32'd9);
        wr(4'd4, 32'd3);
        wr(4'd0, 32'h3);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            we_i = 1'b0; stb_i = 1'b0;
            rd(4'd3, v);
            rd(4'd2, st);
            chk($sformatf("basic_count[%0d]", i), v, 32'((i + 1) % 10));
            chk($sformatf("basic_pwm0[%0d]", i), 32'(pwm[0]), 32'((i % 10) < 3));
            chk($sformatf("basic_wrap[%0d]", i), st,
                32'(((i >= 9) && (i < 23)) || (i >= 29)));
            chk($sformatf("basic_irq[%0d]", i), 32'(irq),
                32'(((i >= 9) && (i < 23)) || (i >= 29)));
            if (i == 18 || i == 22) begin
                adr_i = 4'd2; dat_i = 32'h1; we_i = 1'b1; stb_i = 1'b1;
            end
        end

        // Reset while running: outputs drop without waiting for a clock edge.
        @(negedge clk);
        chk("midrun_pwm_pre", 32'(pwm[0]), 32'h1);
        chk("midrun_irq_pre", 32'(irq), 32'h1);
        #2;
        arst = 1'b1;
        #1;
        chk("midrun_pwm", 32'(pwm), 32'h0);
        chk("midrun_irq", 32'(irq), 32'h0);
        @(negedge clk);
        arst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            chk($sformatf("midrun_reg[%0d]", a), v, 32'h0);
        end
        stb_i = 1'b1;
        #1;
        chk("ack_high", 32'(ack_o), 32'h1);
        stb_i = 1'b0;
        #1;
        chk("ack_low", 32'(ack_o), 32'h0);

        // Prescale: PRE=3, PERIOD=4, DUTY1=2.
        // Sample j has count=((j+1)/4)%5 and pwm1=((j/4)%5)<2.
        do_reset();
        wr(4'd1, 32'd4);
        wr(4'd5, 32'd2);
        wr(4'd0, 32'h301);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            rd(4'd3, v);
            rd(4'd2, st);
            ep = '0;
            ep[1] = ((j / 4) % 5) < 2;
            chk($sformatf("pre_count[%0d]", j), v, 32'(((j + 1) / 4) % 5));
            chk($sformatf("pre_pwm[%0d]", j), 32'(pwm), 32'(ep));
            chk($sformatf("pre_wrap[%0d]", j), st, 32'(j >= 19));
        end

        // Double buffer: DUTY0 goes from 3 to 7 at count 5. The new duty applies only after the wrap at i=9.
        do_reset();
        wr(4'd1, 32'd9);
        wr(4'd4, 32'd3);
        wr(4'd0, 32'h1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            we_i = 1'b0; stb_i = 1'b0;
            rd(4'd3, v);
            chk($sformatf("dbuf_count[%0d]", i), v, 32'((i + 1) % 10));
            chk($sformatf("dbuf_pwm0[%0d]", i), 32'(pwm[0]),
                32'((i % 10) < ((i < 10) ? 3 : 7)));
            if (i == 4) begin
                adr_i = 4'd4; dat_i = 32'd7; we_i = 1'b1; stb_i = 1'b1;
            end
        end
        rd(4'd4, v);
        chk("dbuf_shadow", v, 32'd7);

        // Boundaries: duty 0 is always low, duty 10 above period 9 is always high, and duty 9 is low only at count 9.
        do_reset();
        wr(4'd1, 32'd9);
        wr(4'd4, 32'd0);
        wr(4'd5, 32'd10);
        wr(4'd6, 32'd9);
        wr(4'd0, 32'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ep = 4'b0010;
            ep[2] = (i % 10) < 9;
            chk($sformatf("bound_pwm[%0d]", i), 32'(pwm), 32'(ep));
        end

        // PERIOD=0 with PRE=1: a tick comes every second clock and each tick wraps.
        // A W1C held on every edge clears the flag between wraps, so WRAP alternates.
        do_reset();
        wr(4'd0, 32'h101);
        adr_i = 4'd2; dat_i = 32'h1; we_i = 1'b1; stb_i = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("p0_wrap[%0d]", j), 32'(dat_o[0]), 32'(j % 2 == 1));
        end
        we_i = 1'b0; stb_i = 1'b0;
        rd(4'd3, v);
        chk("p0_count", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
